// File: rtl/ram_acc_pkg.sv
// ram_acc_pkg
// Shared definitions for the RAM4_8 / alu / accumulator sequencer:
// datapath widths, controller state encoding, ALU operation codes and
// the constant table written into the RAM after every reset.
package ram_acc_pkg;

  localparam int WORDSIZE = 8;
  localparam int ADDR_W   = 2;
  localparam int DEPTH    = 4;

  // Address of the last table word; both INIT and the accumulate loop stop here.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    CLR  = 3'd2,
    READ = 3'd3,
    ACC  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Operation codes understood by the external alu.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_t;

  localparam logic [WORDSIZE-1:0] INIT_TABLE [DEPTH] = '{8'd74, 8'd29, 8'd32, 8'd20};

endpackage

// File: rtl/ram_acc_ctrl_rom.sv
// ram_init_rom
// Combinational lookup of the power-up RAM contents.
// Ports:
//   idx  - table index (RAM address being initialised)
//   data - table word for that index
module ram_init_rom
  import ram_acc_pkg::*;
(
  input  logic [ADDR_W-1:0]   idx,
  output logic [WORDSIZE-1:0] data
);

  always_comb begin
    data = INIT_TABLE[idx];
  end

endmodule

// File: rtl/ram_acc_ctrl.sv
// ram_acc_ctrl
// Sequencer for the RAM4_8 / alu / accumulator datapath. After reset it
// writes the constant table into the RAM, then waits in IDLE where the RAM
// address follows user_addr. A start request clears the accumulator, walks
// every RAM word through the alu into the accumulator and captures the
// final accumulator value in result.
// Ports:
//   init_clock, init_reset     - clock, async active-high reset
//   start, op_sel              - run request and alu operation for the run
//   user_addr                  - manual RAM address while idle
//   acc_q, ram_dout            - accumulator output and RAM read data
//   ram_addr, ram_din, ram_we  - RAM control
//   alu_s, acc_en, acc_clr     - alu / accumulator control
//   init_done, busy, done      - status
//   result                     - accumulator value captured at end of run
//
// All outputs are registers loaded from the decode of the current state,
// so each output appears one clock after the state that produces it. This
// keeps the reset values clean while state already sits in INIT, and gives
// the RAM its synchronous read cycle between READ and ACC outputs.
module ram_acc_ctrl
  import ram_acc_pkg::*;
(
  input  logic                init_clock,
  input  logic                init_reset,
  input  logic                start,
  input  logic [1:0]          op_sel,
  input  logic [ADDR_W-1:0]   user_addr,
  input  logic [WORDSIZE-1:0] acc_q,
  input  logic [WORDSIZE-1:0] ram_dout,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [WORDSIZE-1:0] ram_din,
  output logic                ram_we,
  output logic [1:0]          alu_s,
  output logic                acc_en,
  output logic                acc_clr,
  output logic                init_done,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result
);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   idx, next_idx;
  logic [WORDSIZE-1:0] rom_data;

  logic [ADDR_W-1:0]   ram_addr_d;
  logic [WORDSIZE-1:0] ram_din_d;
  logic                ram_we_d;
  logic [1:0]          alu_s_d;
  logic                acc_en_d;
  logic                acc_clr_d;
  logic                init_done_d;
  logic                busy_d;
  logic                done_d;

  // Read data goes straight from the RAM into the alu; the controller never
  // looks at it, so it is only reduced into a deliberately unused net.
  logic unused_ram_dout;
  assign unused_ram_dout = ^ram_dout;

  ram_init_rom u_rom (
    .idx  (idx),
    .data (rom_data)
  );

  // Next-state and output decode. idx doubles as the init write pointer and
  // the accumulate read pointer; it is reset to 0 on leaving INIT and in CLR.
  always_comb begin
    next_state  = state;
    next_idx    = idx;
    ram_addr_d  = '0;
    ram_din_d   = '0;
    ram_we_d    = 1'b0;
    alu_s_d     = alu_s;
    acc_en_d    = 1'b0;
    acc_clr_d   = 1'b0;
    init_done_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state)
      INIT: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = idx;
        ram_din_d   = rom_data;
        init_done_d = 1'b0;
        if (idx == LAST_IDX) begin
          next_state = IDLE;
          next_idx   = '0;
        end else begin
          next_idx = idx + ADDR_W'(1);
        end
      end
      IDLE: begin
        ram_addr_d = user_addr;
        if (start) begin
          alu_s_d    = op_sel;
          next_state = CLR;
        end
      end
      CLR: begin
        acc_clr_d  = 1'b1;
        busy_d     = 1'b1;
        next_idx   = '0;
        next_state = READ;
      end
      READ: begin
        ram_addr_d = idx;
        busy_d     = 1'b1;
        next_state = ACC;
      end
      ACC: begin
        // Address held so the RAM keeps presenting the same word.
        ram_addr_d = idx;
        acc_en_d   = 1'b1;
        busy_d     = 1'b1;
        if (idx == LAST_IDX) begin
          next_state = DONE;
        end else begin
          next_idx   = idx + ADDR_W'(1);
          next_state = READ;
        end
      end
      DONE: begin
        busy_d     = 1'b1;
        done_d     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = INIT;
        next_idx   = '0;
      end
    endcase
  end

  // State, index and registered outputs. result samples acc_q while the done
  // pulse is out: the last accumulator load happened on the edge before it.
  always_ff @(posedge init_clock or posedge init_reset) begin
    if (init_reset) begin
      state     <= INIT;
      idx       <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      alu_s     <= ALU_ADD;
      acc_en    <= 1'b0;
      acc_clr   <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state     <= next_state;
      idx       <= next_idx;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
      ram_we    <= ram_we_d;
      alu_s     <= alu_s_d;
      acc_en    <= acc_en_d;
      acc_clr   <= acc_clr_d;
      init_done <= init_done_d;
      busy      <= busy_d;
      done      <= done_d;
      if (done) begin
        result <= acc_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_acc_ctrl.sv
// tb_ram_acc_ctrl
// Bench for ram_acc_ctrl with behavioural RAM, alu and accumulator models
// attached. Expected run results are queued when a start is driven and
// compared when the controller pulses done.
module tb_ram_acc_ctrl;

  logic       init_clock;
  logic       init_reset;
  logic       start;
  logic [1:0] op_sel;
  logic [1:0] user_addr;
  logic [7:0] acc_q;
  logic [7:0] ram_dout;
  logic [1:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [1:0] alu_s;
  logic       acc_en;
  logic       acc_clr;
  logic       init_done;
  logic       busy;
  logic       done;
  logic [7:0] result;

  ram_acc_ctrl dut (
    .init_clock (init_clock),
    .init_reset (init_reset),
    .start      (start),
    .op_sel     (op_sel),
    .user_addr  (user_addr),
    .acc_q      (acc_q),
    .ram_dout   (ram_dout),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .alu_s      (alu_s),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .init_done  (init_done),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // Clock: 10 ns period
  initial init_clock = 1'b0;
  always #5 init_clock = ~init_clock;

  // RAM model with one-cycle synchronous read
  logic [7:0] mem [4];
  always @(posedge init_clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // alu model
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  logic [7:0] alu_y;
  always_comb begin
    alu_y = alu_f(acc_q, ram_dout, alu_s);
  end

  // Accumulator model
  always @(posedge init_clock or posedge init_reset) begin
    if (init_reset)   acc_q <= 8'd0;
    else if (acc_clr) acc_q <= 8'd0;
    else if (acc_en)  acc_q <= alu_y;
  end

  // Bench bookkeeping
  typedef struct { logic [1:0] op; logic [7:0] res; } exp_t;
  typedef struct { logic [1:0] addr; logic [7:0] exp_dout; } addr_vec_t;

  exp_t       exp_q[$];
  exp_t       pend;
  logic       pend_valid;
  logic [7:0] tbl [4];
  logic [1:0] en_addr[$];
  int         done_cyc[$];
  int         checks;
  int         failures;
  int         cycle;
  int         done_cnt;
  int         clr_cnt;
  int         viol;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_run(input logic [1:0] op);
    logic [7:0] a;
    a = 8'd0;
    for (int i = 0; i < 4; i++) a = alu_f(a, tbl[i], op);
    return a;
  endfunction

  initial begin
    cycle = 0;
    forever begin
      @(posedge init_clock);
      cycle++;
    end
  end

  // Monitor: scoreboard pops on done, invariant tracking, acc_en log
  initial begin
    pend_valid = 1'b0;
    done_cnt = 0;
    clr_cnt = 0;
    viol = 0;
    forever begin
      @(negedge init_clock);
      if (init_reset) begin
        pend_valid = 1'b0;
      end else begin
        if (pend_valid) begin
          checkOutput("run_result", result, pend.res);
          pend_valid = 1'b0;
        end
        if (acc_en && acc_clr) viol++;
        if (ram_we && busy) viol++;
        if (acc_clr) clr_cnt++;
        if (acc_en) en_addr.push_back(ram_addr);
        if (done) begin
          done_cnt++;
          done_cyc.push_back(cycle);
          checkOutput("sb_nonempty_at_done", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            pend = exp_q.pop_front();
            checkOutput("run_alu_s", alu_s, pend.op);
            pend_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge init_clock);
    @(negedge init_clock);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_din", ram_din, 0);
    checkOutput("rst_acc_en", acc_en, 0);
    checkOutput("rst_acc_clr", acc_clr, 0);
    checkOutput("rst_alu_s", alu_s, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 0);
  endtask

  // Release reset and follow the four table writes; start may be held
  // high throughout INIT and is dropped before the first IDLE sample.
  task automatic releaseAndInit(input logic hold_start);
    @(negedge init_clock);
    init_reset = 1'b0;
    start = hold_start;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("init_we", ram_we, 1);
      checkOutput("init_addr", ram_addr, i);
      checkOutput("init_din", ram_din, tbl[i]);
      checkOutput("init_done_low", init_done, 0);
      if (i == 3) start = 1'b0;
    end
    tick();
    checkOutput("post_init_we", ram_we, 0);
    checkOutput("post_init_done", init_done, 1);
    checkOutput("post_init_busy", busy, 0);
  endtask

  // Drive one start pulse, then measure cycles from the sampling edge to
  // the done pulse. op_sel is flipped right after acceptance to prove the
  // latch; poke raises start again mid-run.
  task automatic applyStimulus(input logic [1:0] op, input logic poke, output int lat, output logic busy1);
    clr_cnt = 0;
    en_addr.delete();
    op_sel = op;
    start = 1'b1;
    exp_q.push_back('{op: op, res: model_run(op)});
    @(posedge init_clock);
    @(negedge init_clock);
    start = 1'b0;
    op_sel = ~op;
    lat = 0;
    busy1 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) busy1 = busy;
      if (poke && n == 4) start = 1'b1;
      if (n == 6) start = 1'b0;
      if (done && lat == 0) lat = n;
      if (lat != 0 && n >= lat + 2) break;
    end
  endtask

  initial begin
    int         lat;
    int         d0;
    int         abort_en;
    logic       busy1;
    addr_vec_t  vecs [4];

    checks = 0;
    failures = 0;
    tbl[0] = 8'd74;
    tbl[1] = 8'd29;
    tbl[2] = 8'd32;
    tbl[3] = 8'd20;
    vecs[0] = '{addr: 2'd2, exp_dout: 8'd32};
    vecs[1] = '{addr: 2'd0, exp_dout: 8'd74};
    vecs[2] = '{addr: 2'd3, exp_dout: 8'd20};
    vecs[3] = '{addr: 2'd1, exp_dout: 8'd29};

    init_reset = 1'b1;
    start = 1'b0;
    op_sel = 2'b00;
    user_addr = 2'd0;
    repeat (3) @(negedge init_clock);
    checkResetOutputs();

    releaseAndInit(1'b0);

    // Manual address path in IDLE
    for (int i = 0; i < 4; i++) begin
      user_addr = vecs[i].addr;
      tick();
      checkOutput("idle_ram_addr", ram_addr, vecs[i].addr);
      tick();
      checkOutput("idle_ram_dout", ram_dout, vecs[i].exp_dout);
    end

    // Basic add run
    d0 = done_cnt;
    applyStimulus(2'b00, 1'b0, lat, busy1);
    checkOutput("run_latency", lat, 10);
    checkOutput("run_busy_first", busy1, 1);
    checkOutput("run_clr_count", clr_cnt, 1);
    checkOutput("run_en_count", en_addr.size(), 4);
    if (en_addr.size() == 4)
      for (int i = 0; i < 4; i++) checkOutput("run_en_addr", en_addr[i], i);
    checkOutput("run_done_count", done_cnt - d0, 1);
    repeat (3) tick();
    checkOutput("result_hold", result, 155);
    checkOutput("idle_busy", busy, 0);

    // Subtract run: alu_s must keep the op latched at start
    applyStimulus(2'b01, 1'b0, lat, busy1);
    checkOutput("sub_latency", lat, 10);

    // Start re-asserted mid-run is ignored
    d0 = done_cnt;
    applyStimulus(2'b00, 1'b1, lat, busy1);
    checkOutput("poke_latency", lat, 10);
    checkOutput("poke_done_count", done_cnt - d0, 1);
    tick();

    // Reset during the third accumulate cycle aborts the run
    d0 = done_cnt;
    abort_en = 0;
    op_sel = 2'b00;
    start = 1'b1;
    exp_q.push_back('{op: 2'b00, res: model_run(2'b00)});
    @(posedge init_clock);
    @(negedge init_clock);
    start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (acc_en) abort_en++;
      if (abort_en == 3) break;
    end
    checkOutput("abort_reached_acc3", abort_en, 3);
    init_reset = 1'b1;
    exp_q.delete();
    #1;
    checkResetOutputs();
    repeat (2) @(negedge init_clock);
    releaseAndInit(1'b1);
    checkOutput("abort_no_done", done_cnt - d0, 0);
    applyStimulus(2'b00, 1'b0, lat, busy1);
    checkOutput("after_abort_latency", lat, 10);

    // start held high: exactly two acceptances, 11 cycles apart
    d0 = done_cnt;
    clr_cnt = 0;
    op_sel = 2'b00;
    start = 1'b1;
    exp_q.push_back('{op: 2'b00, res: model_run(2'b00)});
    exp_q.push_back('{op: 2'b00, res: model_run(2'b00)});
    repeat (22) @(posedge init_clock);
    @(negedge init_clock);
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (exp_q.size() == 0 && !pend_valid) break;
      tick();
    end
    checkOutput("b2b_queue_drained", exp_q.size(), 0);
    checkOutput("b2b_done_count", done_cnt - d0, 2);
    checkOutput("b2b_clr_count", clr_cnt, 2);
    if (done_cyc.size() >= 2)
      checkOutput("b2b_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 11);
    checkOutput("b2b_result", result, 155);

    repeat (3) tick();
    checkOutput("invariant_violations", viol, 0);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
